// File: rtl/lsu.sv
// Load/store unit: one outstanding byte/half/word access to DRAM over a ready/valid
// handshake, with alignment/illegal-command faults, a DRAM timeout and load extension.
module lsu #(
  parameter int XLEN        = 32,
  parameter int TID_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             l_req,
  input  logic             s_req,
  input  logic [2:0]       cmd,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [4:0]       rd_addr,
  input  logic [TID_W-1:0] thread_id,
  output logic             dram_req,
  output logic             dram_we,
  output logic [XLEN-1:0]  dram_addr,
  output logic [XLEN-1:0]  dram_wdata,
  output logic [3:0]       dram_be,
  input  logic             dram_ready,
  input  logic             dram_rvalid,
  input  logic [XLEN-1:0]  dram_rdata,
  output logic             lsu_res_en,
  output logic [XLEN-1:0]  lsu_res,
  output logic [4:0]       rd_addr_o,
  output logic [TID_W-1:0] thread_id_o,
  output logic             store_done,
  output logic             err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, RESP, ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_q;
  logic [2:0]         cmd_q;
  logic [XLEN-1:0]    addr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [4:0]         rd_q;
  logic [TID_W-1:0]   tid_q;
  logic [XLEN-1:0]    res_q;
  logic               store_done_q;

  logic               accept;
  logic               legal;
  logic               aligned;
  logic               fault;
  logic               timeout;
  logic [XLEN-1:0]    lane;
  logic [XLEN-1:0]    load_ext;
  logic [3:0]         be;
  logic [XLEN-1:0]    lane_wdata;

  assign accept  = req_valid & (state_q == IDLE) & (l_req | s_req);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Fault classification of the incoming op; unsigned loads have no store counterpart.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (cmd)
      3'b000:  legal = 1'b1;
      3'b001:  begin legal = 1'b1;     aligned = ~addr[0];           end
      3'b010:  begin legal = 1'b1;     aligned = (addr[1:0] == 2'b00); end
      3'b100:  legal = ~s_req;
      3'b101:  begin legal = ~s_req;   aligned = ~addr[0];           end
      default: legal = 1'b0;
    endcase
    fault = (l_req & s_req) | ~legal | ~aligned;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (accept) state_d = fault ? ERR : REQ;
      REQ:     if (dram_ready)  state_d = store_q ? IDLE : WAIT_RD;
               else if (timeout) state_d = ERR;
      WAIT_RD: if (dram_rvalid) state_d = RESP;
               else if (timeout) state_d = ERR;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q)                         cnt_d = '0;
    else if (state_q == REQ || state_q == WAIT_RD)  cnt_d = cnt_q + 1'b1;
  end

  // Shift the addressed byte/half down to bit 0 before extending.
  always_comb begin
    lane = dram_rdata >> {addr_q[1:0], 3'b000};
    case (cmd_q)
      3'b000:  load_ext = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},     lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    case (cmd_q[1:0])
      2'b00:   begin be = 4'b0001 << addr_q[1:0]; lane_wdata = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = 4'b0011 << addr_q[1:0]; lane_wdata = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;                lane_wdata = wdata_q;           end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      tid_q        <= '0;
      res_q        <= '0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_done_q <= (state_q == REQ) & dram_ready & store_q;
      if (accept) begin
        store_q <= s_req;
        cmd_q   <= cmd;
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= rd_addr;
        tid_q   <= thread_id;
      end
      if (state_q == WAIT_RD && dram_rvalid) res_q <= load_ext;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign dram_req    = (state_q == REQ);
  assign dram_we     = (state_q == REQ) & store_q;
  assign dram_be     = (state_q == REQ) ? be : 4'b0000;
  assign dram_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign dram_wdata  = lane_wdata;
  assign lsu_res_en  = (state_q == RESP) & (rd_q != 5'd0);
  assign lsu_res     = res_q;
  assign rd_addr_o   = rd_q;
  assign thread_id_o = tid_q;
  assign store_done  = store_done_q;
  assign err_o       = (state_q == ERR);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops checked against an
// arithmetic reference model, with a DRAM responder of random ready/rvalid delay.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, l_req, s_req;
  logic [2:0]  cmd;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_addr;
  logic [1:0]  thread_id;
  logic        dram_req, dram_we, dram_ready, dram_rvalid;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [3:0]  dram_be;
  logic        lsu_res_en, store_done, err_o;
  logic [31:0] lsu_res;
  logic [4:0]  rd_addr_o;
  logic [1:0]  thread_id_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .l_req(l_req), .s_req(s_req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .rd_addr(rd_addr), .thread_id(thread_id), .dram_req(dram_req), .dram_we(dram_we),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_be(dram_be),
    .dram_ready(dram_ready), .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .lsu_res_en(lsu_res_en), .lsu_res(lsu_res), .rd_addr_o(rd_addr_o),
    .thread_id_o(thread_id_o), .store_done(store_done), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the op's rules.
  function automatic bit m_fault(bit l, bit s, logic [2:0] c, logic [31:0] a);
    if (l && s) return 1'b1;
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      3'd4:    return s;
      3'd5:    return s || ((a % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] c, logic [31:0] a);
    int off = int'(a % 4);
    if (c == 3'd0) return 4'(1 << off);
    if (c == 3'd1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] c, logic [31:0] w);
    if (c == 3'd0) return (w & 32'hFF) * 32'h01010101;
    if (c == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] c, logic [31:0] a, logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * (a % 4))) & 32'hFF;
    h = (r >> (8 * (a % 4))) & 32'hFFFF;
    case (c)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return r;
    endcase
  endfunction

  task automatic do_op(input bit l, input bit s, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd, input logic [1:0] tid,
                       input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; l_req = l; s_req = s; cmd = c; addr = a; wdata = w;
    rd_addr = rd; thread_id = tid;
    step();
    req_valid = 1'b0; l_req = 1'b0; s_req = 1'b0;
    addr = $urandom; wdata = $urandom;
    if (m_fault(l, s, c, a)) begin
      check("err_pulse", err_o, 1);
      check("err_no_dram", dram_req, 0);
      check("err_tid", thread_id_o, tid);
      check("err_no_res", lsu_res_en, 0);
      step();
      check("err_end", err_o, 0);
      check("err_ready_back", req_ready, 1);
      check("err_no_dram2", dram_req, 0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      check("req_valid_out", dram_req, 1);
      check("req_busy", req_ready, 0);
      check("req_addr", dram_addr, a & 32'hFFFF_FFFC);
      check("req_we", dram_we, s);
      if (s) begin
        check("req_be", dram_be, m_be(c, a));
        check("req_wdata", dram_wdata, m_wdata(c, w));
      end
      if (i == rdy_dly) dram_ready = 1'b1;
      step();
    end
    dram_ready = 1'b0;
    if (s) begin
      check("store_done", store_done, 1);
      check("store_ready_back", req_ready, 1);
      check("store_req_low", dram_req, 0);
      step();
      check("store_done_pulse", store_done, 0);
      return;
    end
    for (int i = 0; i <= rv_dly; i++) begin
      check("wait_req_low", dram_req, 0);
      check("wait_be_zero", dram_be, 0);
      check("wait_no_res", lsu_res_en, 0);
      if (i == rv_dly) begin
        dram_rvalid = 1'b1;
        dram_rdata  = rdata;
      end
      step();
    end
    dram_rvalid = 1'b0;
    dram_rdata  = $urandom;
    check("res_en", lsu_res_en, (rd != 5'd0));
    if (rd != 5'd0) check("res_data", lsu_res, m_load(c, a, rdata));
    check("res_rd", rd_addr_o, rd);
    check("res_tid", thread_id_o, tid);
    check("res_busy", req_ready, 0);
    step();
    check("res_pulse", lsu_res_en, 0);
    check("res_ready_back", req_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; l_req = 1'b0; s_req = 1'b0; cmd = '0; addr = '0;
    wdata = '0; rd_addr = '0; thread_id = '0; dram_ready = 1'b0; dram_rvalid = 1'b0;
    dram_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_ready", req_ready, 1);
    check("rst_dram_req", dram_req, 0);
    check("rst_dram_we", dram_we, 0);
    check("rst_be", dram_be, 0);
    check("rst_addr", dram_addr, 0);
    check("rst_wdata", dram_wdata, 0);
    check("rst_res", lsu_res, 0);
    check("rst_res_en", lsu_res_en, 0);
    check("rst_rd", rd_addr_o, 0);
    check("rst_tid", thread_id_o, 0);
    check("rst_err", err_o, 0);
    check("rst_sdone", store_done, 0);

    do_op(1, 0, 3'd2, 32'h100, 0, 5'd5, 2'd2, 0, 0, 32'hDEADBEEF);
    check("lw_value", lsu_res, 32'hDEADBEEF);
    do_op(1, 0, 3'd0, 32'h103, 0, 5'd6, 2'd1, 0, 0, 32'h80112233);
    check("lb_value", lsu_res, 32'hFFFFFF80);
    do_op(1, 0, 3'd4, 32'h103, 0, 5'd6, 2'd1, 0, 0, 32'h80112233);
    check("lbu_value", lsu_res, 32'h00000080);
    do_op(1, 0, 3'd5, 32'h102, 0, 5'd7, 2'd3, 0, 0, 32'h80112233);
    check("lhu_value", lsu_res, 32'h00008011);
    do_op(0, 1, 3'd1, 32'h206, 32'h1234ABCD, 5'd0, 2'd0, 0, 0, 0);
    do_op(1, 0, 3'd2, 32'h101, 0, 5'd3, 2'd1, 0, 0, 0);
    do_op(0, 1, 3'd2, 32'h20C, 32'hCAFEF00D, 5'd0, 2'd3, 3, 0, 0);
    do_op(1, 0, 3'd1, 32'h10E, 0, 5'd0, 2'd2, 1, 2, 32'h7FFF8001);

    // DRAM never ready: request held for the full timeout window, then err_o.
    req_valid = 1'b1; s_req = 1'b1; cmd = 3'd2; addr = 32'h300; wdata = 32'h1; thread_id = 2'd1;
    step();
    req_valid = 1'b0; s_req = 1'b0;
    n = 0;
    while (dram_req && n < 400) begin
      n++;
      step();
    end
    check("timeout_cycles", n, 255);
    check("timeout_err", err_o, 1);
    check("timeout_tid", thread_id_o, 1);
    step();
    check("timeout_err_end", err_o, 0);
    check("timeout_ready", req_ready, 1);

    // Reset while waiting for read data, then a late rvalid.
    req_valid = 1'b1; l_req = 1'b1; cmd = 3'd2; addr = 32'h40; rd_addr = 5'd7; thread_id = 2'd3;
    step();
    req_valid = 1'b0; l_req = 1'b0;
    dram_ready = 1'b1;
    step();
    dram_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dram_rvalid = 1'b1; dram_rdata = 32'h12345678;
    step();
    dram_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstmid_res_en", lsu_res_en, 0);
      check("rstmid_err", err_o, 0);
      check("rstmid_sdone", store_done, 0);
      check("rstmid_ready", req_ready, 1);
      check("rstmid_dram_req", dram_req, 0);
      check("rstmid_addr", dram_addr, 0);
      check("rstmid_res", lsu_res, 0);
      check("rstmid_rd", rd_addr_o, 0);
      check("rstmid_tid", thread_id_o, 0);
      step();
    end

    for (int k = 0; k < 200; k++) begin
      bit l, s;
      logic [2:0] c;
      l = $urandom_range(0, 1);
      s = !l;
      if ($urandom_range(0, 15) == 0) begin l = 1; s = 1; end
      c = 3'($urandom_range(0, 7));
      do_op(l, s, c, {22'h0, 8'($urandom), 2'($urandom)}, $urandom, 5'($urandom),
            2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
